// File: rtl/gates100_reduce_if.sv
// Bus bundle for the 100-input reduction block: input vector plus the
// combinational and registered reduction results.
interface gates100_reduce_if #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned CNT_W = 7
);
    logic [WIDTH-1:0] din;
    logic             out_and;
    logic             out_or;
    logic             out_xor;
    logic             out_and_q;
    logic             out_or_q;
    logic             out_xor_q;
    logic [CNT_W-1:0] ones_cnt_q;

    modport master (
        output din,
        input  out_and, out_or, out_xor,
        input  out_and_q, out_or_q, out_xor_q, ones_cnt_q
    );

    modport slave (
        input  din,
        output out_and, out_or, out_xor,
        output out_and_q, out_or_q, out_xor_q, ones_cnt_q
    );
endinterface

// File: rtl/gates100_reduce.sv
// AND/OR/XOR reduction of a WIDTH-bit vector with zero-latency outputs, plus
// one-cycle registered copies and a registered adder-tree population count.
module gates100_reduce #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned CNT_W = 7
) (
    input logic                 clk,
    input logic                 rst_n,
    gates100_reduce_if.slave    bus
);
    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LEAVES = 1 << LEVELS;

    logic             out_and_d, out_or_d, out_xor_d;
    logic             out_and_q, out_or_q, out_xor_q;
    logic [CNT_W-1:0] ones_cnt_d, ones_cnt_q;

    assign bus.out_and = &bus.din;
    assign bus.out_or  = |bus.din;
    assign bus.out_xor = ^bus.din;

    // Pairwise adder tree; leaves beyond WIDTH are tied to zero, and partial
    // sums never exceed WIDTH so CNT_W bits cannot wrap.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int unsigned N = LEAVES >> l;
        logic [CNT_W-1:0] s [N];
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_bit
                if (i < WIDTH) begin : g_in
                    assign s[i] = CNT_W'(bus.din[i]);
                end else begin : g_pad
                    assign s[i] = '0;
                end
            end
        end else begin : g_sum
            for (genvar i = 0; i < N; i++) begin : g_add
                assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
            end
        end
    end

    always_comb begin
        out_and_d  = bus.out_and;
        out_or_d   = bus.out_or;
        out_xor_d  = bus.out_xor;
        ones_cnt_d = g_lvl[LEVELS].s[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_and_q  <= 1'b0;
            out_or_q   <= 1'b0;
            out_xor_q  <= 1'b0;
            ones_cnt_q <= '0;
        end else begin
            out_and_q  <= out_and_d;
            out_or_q   <= out_or_d;
            out_xor_q  <= out_xor_d;
            ones_cnt_q <= ones_cnt_d;
        end
    end

    assign bus.out_and_q  = out_and_q;
    assign bus.out_or_q   = out_or_q;
    assign bus.out_xor_q  = out_xor_q;
    assign bus.ones_cnt_q = ones_cnt_q;
endmodule

// File: tb/tb_gates100_reduce.sv
// Directed and random checks of gates100_reduce with a queue of expected
// registered results, one entry per rising edge.
module tb_gates100_reduce;
    localparam int unsigned WIDTH = 100;
    localparam int unsigned CNT_W = 7;

    typedef struct packed {
        logic             a;
        logic             o;
        logic             x;
        logic [CNT_W-1:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    int unsigned n_checks;
    int unsigned n_fail;
    exp_t exp_q [$];

    gates100_reduce_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    gates100_reduce #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [WIDTH-1:0] v);
        exp_t e;
        int unsigned n;
        n   = $countones(v);
        e.c = CNT_W'(n);
        e.a = (n == WIDTH);
        e.o = (n != 0);
        e.x = n[0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input string tag, input logic [WIDTH-1:0] v);
        exp_t e;
        bus.din = v;
        #1;
        e = model(v);
        chk({tag, ".and"}, 32'(bus.out_and), 32'(e.a));
        chk({tag, ".or"},  32'(bus.out_or),  32'(e.o));
        chk({tag, ".xor"}, 32'(bus.out_xor), 32'(e.x));
    endtask

    task automatic step_edge(input string tag);
        exp_t e;
        exp_q.push_back(model(bus.din));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".and_q"}, 32'(bus.out_and_q),  32'(e.a));
        chk({tag, ".or_q"},  32'(bus.out_or_q),   32'(e.o));
        chk({tag, ".xor_q"}, 32'(bus.out_xor_q),  32'(e.x));
        chk({tag, ".cnt_q"}, 32'(bus.ones_cnt_q), 32'(e.c));
    endtask

    task automatic chk_q_zero(input string tag);
        chk({tag, ".and_q"}, 32'(bus.out_and_q),  32'd0);
        chk({tag, ".or_q"},  32'(bus.out_or_q),   32'd0);
        chk({tag, ".xor_q"}, 32'(bus.out_xor_q),  32'd0);
        chk({tag, ".cnt_q"}, 32'(bus.ones_cnt_q), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] low18;
        logic [WIDTH-1:0] va, vb;
        n_checks = 0;
        n_fail   = 0;
        clk      = 1'b0;
        rst_n    = 1'b0;
        bus.din  = '0;
        one      = '0;
        one[0]   = 1'b1;
        low18    = WIDTH'(18'h3FFFF);

        #2;
        chk_q_zero("reset");
        drive("reset_comb_ones", '1);
        chk("reset_hold.cnt_q", 32'(bus.ones_cnt_q), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive("zero", '0);
        step_edge("zero");
        drive("ones", '1);
        step_edge("ones");
        chk("ones.cnt100", 32'(bus.ones_cnt_q), 32'd100);
        drive("low18", low18);
        step_edge("low18");
        chk("low18.cnt18", 32'(bus.ones_cnt_q), 32'd18);
        drive("high82", ~low18);
        step_edge("high82");
        chk("high82.cnt82", 32'(bus.ones_cnt_q), 32'd82);

        for (int k = 0; k < 10; k++) begin
            drive("count", WIDTH'(k));
            step_edge("count");
        end
        drive("count7", WIDTH'(7));
        step_edge("count7");
        chk("count7.xor_lit", 32'(bus.out_xor_q), 32'd1);

        // Alternate which pattern lands on the rising edge so both get a
        // registered check across the walk.
        for (int i = 0; i < int'(WIDTH); i++) begin
            va = one << i;
            vb = ~(one << i);
            if (i % 2 == 1) begin
                va = ~(one << i);
                vb = one << i;
            end
            drive("walk_a", va);
            @(negedge clk);
            drive("walk_b", vb);
            step_edge("walk");
        end

        for (int r = 0; r < 100; r++) begin
            va = {$urandom, $urandom, $urandom, $urandom};
            vb = {$urandom, $urandom, $urandom, $urandom};
            if (r == 30) va = ~(one << (WIDTH - 1));
            drive("rand_a", va);
            @(negedge clk);
            drive("rand_b", vb);
            step_edge("rand");
            if (r == 50) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk_q_zero("mid_reset");
                drive("mid_reset_comb", {$urandom, $urandom, $urandom, $urandom});
                @(posedge clk);
                #1;
                chk_q_zero("mid_reset_hold");
                drive("mid_reset_comb2", '1);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
